flu_length_meter: RTL and testbench
===================================

Name: flu_length_meter

Overview:
- Transparent FrameLinkUnaligned (FLU) pass-through that measures the byte length of every frame crossing it.
- Each completed frame's length is pushed into a small internal FIFO and offered on a LENGTH / LENGTH_READY / LENGTH_NEXT producer port.
- Sits upstream of length-consuming blocks such as trimming units or header editors, and supplies their per-frame length stream.

Parameters:
- DATA_WIDTH, 256, FLU data width in bits; multiple of 8.
- SOP_POS_WIDTH, 2, SOP granularity; block size = DATA_WIDTH/8/2^SOP_POS_WIDTH bytes.
- LENGTH_WIDTH, 16, width of the reported length in bytes.
- FIFO_ITEMS, 4, depth of the length FIFO; power of 2, >= 2.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-high.
- RX_DATA  in  DATA_WIDTH  FLU input data.
- RX_SOP_POS  in  SOP_POS_WIDTH  SOP block index.
- RX_EOP_POS  in  log2(DATA_WIDTH/8)  EOP byte index.
- RX_SOP, RX_EOP, RX_SRC_RDY  in  1  FLU input control.
- RX_DST_RDY  out  1  input accept.
- TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP, TX_SRC_RDY  out  as RX  FLU output.
- TX_DST_RDY  in  1  output accept.
- LENGTH  out  LENGTH_WIDTH  length of the oldest measured frame, in bytes.
- LENGTH_READY  out  1  LENGTH valid (FIFO not empty).
- LENGTH_NEXT  in  1  consumer pops LENGTH.

Behaviour:
- Reset:
  - Takes effect synchronously on CLK; the sole clock is CLK.
  - Empties the FIFO (LENGTH_READY=0, LENGTH=0).
  - Clears the byte counter to 0 and the in_frame flag to 0.
- Datapath:
  - TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP and TX_EOP are wired through from RX with zero latency.
  - TX_SRC_RDY = RX_SRC_RDY and not fifo_full.
  - RX_DST_RDY = TX_DST_RDY and not fifo_full.
- Transfer: xfer = RX_SRC_RDY and RX_DST_RDY. All state changes only on xfer.
- Derived byte positions:
  - sop_byte = RX_SOP_POS * block bytes.
  - W = DATA_WIDTH/8.
- Counter update per xfer word:
  - in_frame=1, no SOP, no EOP: cnt += W.
  - in_frame=1, EOP: push cnt + RX_EOP_POS + 1.
    - If SOP is also asserted (required sop_byte > RX_EOP_POS), a new frame starts: cnt = W - sop_byte, in_frame stays 1.
    - Otherwise in_frame=0.
  - in_frame=0, SOP and EOP with sop_byte <= RX_EOP_POS: single-word frame; push RX_EOP_POS + 1 - sop_byte; in_frame stays 0.
  - in_frame=0, SOP only: cnt = W - sop_byte, in_frame=1.
  - in_frame=0, EOP without SOP: protocol violation; ignored, no push.
- Width rule: the counter saturates at 2^LENGTH_WIDTH-1; a saturated value is reported as is.
- FIFO:
  - A push occurs only on xfer with EOP ending a frame.
  - A pushed length is visible on LENGTH with LENGTH_READY=1 in the cycle after the EOP transfer (1-cycle latency).
  - Pop when LENGTH_NEXT=1 and LENGTH_READY=1; LENGTH_NEXT while empty is ignored.
  - Simultaneous push and pop: both take effect and occupancy is unchanged.
  - fifo_full is asserted when occupancy = FIFO_ITEMS. While full, RX is stalled as a whole word, so at most one push per word can never overflow.
  - Pointers wrap modulo FIFO_ITEMS.
- Stall: with TX_DST_RDY=0 there is no xfer; counter and flag hold.
- Reset mid-frame: the partial frame is discarded and nothing is pushed. A frame whose SOP is seen after reset is measured correctly.

Decomposition:
- Package flu_length_meter_pkg holds:
  - the log2 helper;
  - constants W_BYTES and BLOCK_BYTES, derived from the parameters;
  - the length_t typedef (LENGTH_WIDTH bits).
- One sub-module, flu_length_fifo: synchronous FIFO, FIFO_ITEMS x LENGTH_WIDTH, with push, pop, full and empty, reset by RESET.
- Counter and frame-flag logic live in the top level.

Test Plan (DATA_WIDTH=256, SOP_POS_WIDTH=2, block 8 B, LENGTH_WIDTH=16, FIFO_ITEMS=4):
1. Single word, SOP_POS=0, EOP_POS=31 -> LENGTH=32 with LENGTH_READY=1 one cycle later; minimal frame SOP_POS=3, EOP_POS=24 -> LENGTH=1.
2. SOP_POS=1 (byte 8), then one middle word, then EOP_POS=3 -> LENGTH=24+32+4=60.
3. Frame A: SOP_POS=0, then next word EOP_POS=9 with SOP_POS=2; frame B ends next word at EOP_POS=0 -> lengths 42 then 17, in order.
4. Five single-word frames with LENGTH_NEXT=0 -> RX_DST_RDY=0 and TX_SRC_RDY=0 on the 5th; one LENGTH_NEXT pulse -> 5th accepted next cycle; pops return the lengths in FIFO order.
5. TX_DST_RDY=0 for 3 cycles mid-frame (frame SOP_POS=0, then a middle word held during the stall, then EOP_POS=0) -> no counting, TX mirrors RX, final length 65 is unaffected by the stall.
6. RESET=1 mid-frame with 2 lengths queued -> LENGTH_READY=0; a following frame with SOP_POS=0, EOP_POS=15 -> LENGTH=16 as the sole entry.

Source files
------------

// File: rtl/flu_length_meter_pkg.sv
// Shared constants, helper and types for the FLU length meter.
package flu_length_meter_pkg;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DATA_WIDTH_D    = 256;
    localparam int SOP_POS_WIDTH_D = 2;
    localparam int LENGTH_WIDTH_D  = 16;
    localparam int FIFO_ITEMS_D    = 4;

    localparam int W_BYTES     = DATA_WIDTH_D / 8;
    localparam int BLOCK_BYTES = W_BYTES >> SOP_POS_WIDTH_D;

    typedef logic [LENGTH_WIDTH_D-1:0] length_t;

endpackage

// File: rtl/flu_length_fifo.sv
// Small synchronous FIFO holding measured frame lengths.
module flu_length_fifo
    import flu_length_meter_pkg::*;
#(
    parameter int ITEMS = FIFO_ITEMS_D,
    parameter int WIDTH = LENGTH_WIDTH_D
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = log2(ITEMS);

    logic [WIDTH-1:0] mem [ITEMS];
    logic [AW-1:0]    wr;
    logic [AW-1:0]    rd;
    logic [AW:0]      cnt;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt == (AW+1)'(ITEMS));
    assign empty = (cnt == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = empty ? '0 : mem[rd];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            if (rd_en) rd <= rd + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr] <= din;
    end

endmodule

// File: rtl/flu_length_meter.sv
// FLU pass-through that measures each frame's byte length into a FIFO.
module flu_length_meter
    import flu_length_meter_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_D,
    parameter int SOP_POS_WIDTH = SOP_POS_WIDTH_D,
    parameter int LENGTH_WIDTH  = LENGTH_WIDTH_D,
    parameter int FIFO_ITEMS    = FIFO_ITEMS_D
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [DATA_WIDTH-1:0]              RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0]           RX_SOP_POS,
    input  logic [log2(DATA_WIDTH/8)-1:0]      RX_EOP_POS,
    input  logic                               RX_SOP,
    input  logic                               RX_EOP,
    input  logic                               RX_SRC_RDY,
    output logic                               RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]              TX_DATA,
    output logic [SOP_POS_WIDTH-1:0]           TX_SOP_POS,
    output logic [log2(DATA_WIDTH/8)-1:0]      TX_EOP_POS,
    output logic                               TX_SOP,
    output logic                               TX_EOP,
    output logic                               TX_SRC_RDY,
    input  logic                               TX_DST_RDY,
    output logic [LENGTH_WIDTH-1:0]            LENGTH,
    output logic                               LENGTH_READY,
    input  logic                               LENGTH_NEXT
);
    localparam int WB  = DATA_WIDTH / 8;
    localparam int BLK = WB >> SOP_POS_WIDTH;
    localparam int EW  = log2(WB);
    localparam int SW  = LENGTH_WIDTH + EW + 2;

    logic [LENGTH_WIDTH-1:0] cnt, cnt_n, push_len;
    logic                    in_frame, inf_n;
    logic                    push, full, empty, xfer;
    logic [SW-1:0]           sop_b, eop_b, end_len, mid_len, start_len, one_len;

    // Wide intermediate sums are clamped back to the reported width.
    function automatic logic [LENGTH_WIDTH-1:0] sat(input logic [SW-1:0] v);
        return (|v[SW-1:LENGTH_WIDTH]) ? '1 : v[LENGTH_WIDTH-1:0];
    endfunction

    assign TX_DATA    = RX_DATA;
    assign TX_SOP_POS = RX_SOP_POS;
    assign TX_EOP_POS = RX_EOP_POS;
    assign TX_SOP     = RX_SOP;
    assign TX_EOP     = RX_EOP;
    assign TX_SRC_RDY = RX_SRC_RDY & ~full;
    assign RX_DST_RDY = TX_DST_RDY & ~full;
    assign xfer       = RX_SRC_RDY & RX_DST_RDY;

    assign sop_b     = SW'(RX_SOP_POS) * SW'(BLK);
    assign eop_b     = SW'(RX_EOP_POS);
    assign end_len   = SW'(cnt) + eop_b + SW'(1);
    assign mid_len   = SW'(cnt) + SW'(WB);
    assign start_len = SW'(WB) - sop_b;
    assign one_len   = eop_b + SW'(1) - sop_b;

    always_comb begin
        push     = 1'b0;
        push_len = '0;
        cnt_n    = cnt;
        inf_n    = in_frame;
        if (xfer) begin
            if (in_frame) begin
                if (RX_EOP) begin
                    push     = 1'b1;
                    push_len = sat(end_len);
                    if (RX_SOP) cnt_n = sat(start_len);
                    else        inf_n = 1'b0;
                end else if (RX_SOP) begin
                    cnt_n = sat(start_len);
                end else begin
                    cnt_n = sat(mid_len);
                end
            end else if (RX_SOP && RX_EOP && sop_b <= eop_b) begin
                push     = 1'b1;
                push_len = sat(one_len);
            end else if (RX_SOP) begin
                cnt_n = sat(start_len);
                inf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt      <= '0;
            in_frame <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            in_frame <= inf_n;
        end
    end

    flu_length_fifo #(
        .ITEMS (FIFO_ITEMS),
        .WIDTH (LENGTH_WIDTH)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .pop   (LENGTH_NEXT),
        .din   (push_len),
        .dout  (LENGTH),
        .full  (full),
        .empty (empty)
    );

    assign LENGTH_READY = ~empty;

endmodule

// File: tb/tb_flu_length_meter.sv
// Table-driven and scoreboard bench for flu_length_meter.
module tb_flu_length_meter;
    import flu_length_meter_pkg::*;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [255:0]   RX_DATA;
    logic [1:0]     RX_SOP_POS;
    logic [4:0]     RX_EOP_POS;
    logic           RX_SOP, RX_EOP, RX_SRC_RDY;
    logic           RX_DST_RDY;
    logic [255:0]   TX_DATA;
    logic [1:0]     TX_SOP_POS;
    logic [4:0]     TX_EOP_POS;
    logic           TX_SOP, TX_EOP, TX_SRC_RDY;
    logic           TX_DST_RDY;
    length_t        LENGTH;
    logic           LENGTH_READY;
    logic           LENGTH_NEXT;

    int total = 0;
    int bad   = 0;
    int q[$];

    typedef struct {
        logic sop;
        int   sp;
        logic eop;
        int   ep;
        int   len;
    } vec_t;

    vec_t tbl[11];

    always #5 CLK = ~CLK;

    flu_length_meter dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_DATA      (RX_DATA),
        .RX_SOP_POS   (RX_SOP_POS),
        .RX_EOP_POS   (RX_EOP_POS),
        .RX_SOP       (RX_SOP),
        .RX_EOP       (RX_EOP),
        .RX_SRC_RDY   (RX_SRC_RDY),
        .RX_DST_RDY   (RX_DST_RDY),
        .TX_DATA      (TX_DATA),
        .TX_SOP_POS   (TX_SOP_POS),
        .TX_EOP_POS   (TX_EOP_POS),
        .TX_SOP       (TX_SOP),
        .TX_EOP       (TX_EOP),
        .TX_SRC_RDY   (TX_SRC_RDY),
        .TX_DST_RDY   (TX_DST_RDY),
        .LENGTH       (LENGTH),
        .LENGTH_READY (LENGTH_READY),
        .LENGTH_NEXT  (LENGTH_NEXT)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mirror_chk(input logic src_exp);
        chk("tx_data",    TX_DATA == RX_DATA, 1);
        chk("tx_ctl",     {TX_SOP, TX_EOP, TX_SOP_POS, TX_EOP_POS},
                          {RX_SOP, RX_EOP, RX_SOP_POS, RX_EOP_POS});
        chk("tx_src_rdy", TX_SRC_RDY, src_exp);
    endtask

    task automatic set_word(input logic sop, input int sp, input logic eop, input int ep);
        RX_SOP     = sop;
        RX_EOP     = eop;
        RX_SOP_POS = 2'(sp);
        RX_EOP_POS = 5'(ep);
        RX_DATA    = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
        RX_SRC_RDY = 1'b1;
    endtask

    task automatic idle_rx();
        RX_SRC_RDY = 1'b0;
        RX_SOP     = 1'b0;
        RX_EOP     = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after transfer.
    task automatic drive(input logic sop, input int sp, input logic eop,
                         input int ep, input int len);
        int n;
        set_word(sop, sp, eop, ep);
        #1;
        chk("ready_view", LENGTH_READY, q.size() != 0);
        mirror_chk(q.size() < 4);
        n = 0;
        while (!RX_DST_RDY && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("accept", RX_DST_RDY, 1);
        if (len >= 0) q.push_back(len);
        @(posedge CLK);
        @(negedge CLK);
        idle_rx();
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            chk("len_ready", LENGTH_READY, 1);
            chk("len_value", LENGTH, q[0]);
            void'(q.pop_front());
            LENGTH_NEXT = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            LENGTH_NEXT = 1'b0;
        end
        chk("len_empty", LENGTH_READY, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 0, 1'b1, 31, 32};
        tbl[1]  = '{1'b1, 3, 1'b1, 24, 1};
        tbl[2]  = '{1'b1, 1, 1'b0, 0, -1};
        tbl[3]  = '{1'b0, 0, 1'b0, 0, -1};
        tbl[4]  = '{1'b0, 0, 1'b1, 3, 60};
        tbl[5]  = '{1'b1, 0, 1'b0, 0, -1};
        tbl[6]  = '{1'b1, 2, 1'b1, 9, 42};
        tbl[7]  = '{1'b0, 0, 1'b1, 0, 17};
        tbl[8]  = '{1'b0, 0, 1'b1, 5, -1};
        tbl[9]  = '{1'b1, 3, 1'b1, 5, -1};
        tbl[10] = '{1'b0, 0, 1'b1, 7, 16};

        RESET       = 1'b1;
        RX_DATA     = '0;
        RX_SOP_POS  = '0;
        RX_EOP_POS  = '0;
        idle_rx();
        TX_DST_RDY  = 1'b1;
        LENGTH_NEXT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ready",  LENGTH_READY, 0);
        chk("rst_length", LENGTH, 0);
        chk("rst_dst",    RX_DST_RDY, 1);
        RESET = 1'b0;
        @(negedge CLK);

        // Vector table: single-word, multi-word and back-to-back frames.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].sop, tbl[i].sp, tbl[i].eop, tbl[i].ep, tbl[i].len);
            if (q.size() >= 3) drain();
        end
        drain();

        // FIFO full: fifth frame stalls until one pop.
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 1'b1, i, i + 1);
        set_word(1'b1, 0, 1'b1, 4);
        #1;
        chk("full_dst", RX_DST_RDY, 0);
        mirror_chk(1'b0);
        repeat (2) @(negedge CLK);
        #1;
        chk("full_hold", RX_DST_RDY, 0);
        chk("full_len",  LENGTH, q[0]);
        void'(q.pop_front());
        LENGTH_NEXT = 1'b1;
        @(posedge CLK);
        #1;
        chk("unfull_dst", RX_DST_RDY, 1);
        @(negedge CLK);
        LENGTH_NEXT = 1'b0;
        q.push_back(5);
        @(posedge CLK);
        @(negedge CLK);
        idle_rx();
        drain();

        // Output stall in the middle of a frame.
        drive(1'b1, 0, 1'b0, 0, -1);
        TX_DST_RDY = 1'b0;
        set_word(1'b0, 0, 1'b0, 0);
        repeat (3) begin
            #1;
            chk("stall_dst", RX_DST_RDY, 0);
            mirror_chk(1'b1);
            @(negedge CLK);
        end
        TX_DST_RDY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        idle_rx();
        drive(1'b0, 0, 1'b1, 0, 65);
        drain();

        // Counter saturation on a very long frame.
        drive(1'b1, 0, 1'b0, 0, -1);
        repeat (2100) drive(1'b0, 0, 1'b0, 0, -1);
        drive(1'b0, 0, 1'b1, 31, 65535);
        drain();

        // Reset mid-frame with queued lengths.
        drive(1'b1, 0, 1'b1, 31, 32);
        drive(1'b1, 0, 1'b1, 7, 8);
        drive(1'b1, 0, 1'b0, 0, -1);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        q.delete();
        chk("rst2_ready",  LENGTH_READY, 0);
        chk("rst2_length", LENGTH, 0);
        drive(1'b0, 0, 1'b1, 3, -1);
        drive(1'b1, 0, 1'b1, 15, 16);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
